// File: rtl/cu_seq_multicycle.sv
// Multi-cycle control sequencer for a LEGv8-style datapath: owns the instruction
// register, decodes ALU/memory/branch classes and handshakes with both memories.
//
// state  | meaning
// FETCH  | request instruction word, load ir on ready
// DECODE | classify ir, flag illegal encodings
// EXEC   | drive ALU operand select, resolve branches
// MEM    | data memory access (load or store)
// WB     | register-file write and retire
// HALT   | memory timeout, wait for reset
module cu_seq_multicycle #(
    parameter int K_W      = 32,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_imem_ready,
    output logic             o_imem_req,
    input  logic             i_dmem_ready,
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    input  logic [3:0]       i_status,
    input  logic             i_alu_zero,
    output logic [31:0]      o_ir,
    output logic [K_W-1:0]   o_k,
    output logic             o_pc_inc,
    output logic             o_pc_load,
    output logic             o_reg_we,
    output logic             o_alu_b_k,
    output logic             o_illegal,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_DPI   = 3'd1,
        C_DPR   = 3'd2,
        C_LD    = 3'd3,
        C_ST    = 3'd4,
        C_B     = 3'd5,
        C_BCOND = 3'd6,
        C_CB    = 3'd7
    } cls_t;

    localparam logic [7:0] WAIT_LIM = WAIT_MAX[7:0];

    state_t             r_state;
    state_t             w_next;
    cls_t               r_cls;
    cls_t               w_cls;
    logic               r_cbnz;
    logic [31:0]        r_ir;
    logic [7:0]         r_wait;
    logic               r_fault;
    logic [CNT_W-1:0]   r_retired;

    logic               w_load_ir;
    logic               w_retire;
    logic               w_set_fault;
    logic               w_waiting;
    logic               w_timeout;
    logic               w_cond;
    logic               w_taken;
    logic [K_W-1:0]     w_k;
    logic               w_unused;

    logic               w_imem_req;
    logic               w_dmem_req;
    logic               w_dmem_we;
    logic               w_pc_inc;
    logic               w_pc_load;
    logic               w_reg_we;
    logic               w_alu_b_k;
    logic               w_illegal;

    // The carry flag is not consumed by any supported condition code.
    assign w_unused = i_status[1];

    always_comb begin
        w_cls = C_NONE;
        if (r_ir[28:26] == 3'b100) begin
            w_cls = C_DPI;
        end else if (r_ir[27:25] == 3'b101) begin
            w_cls = C_DPR;
        end else if (r_ir[27] && !r_ir[25]) begin
            w_cls = r_ir[22] ? C_LD : C_ST;
        end else if (r_ir[28:26] == 3'b101) begin
            if (r_ir[31:26] == 6'b000101) begin
                w_cls = C_B;
            end else if (r_ir[31:24] == 8'b01010100) begin
                w_cls = C_BCOND;
            end else if (r_ir[31:25] == 7'b1011010) begin
                w_cls = C_CB;
            end
        end
    end

    always_comb begin
        w_k = '0;
        case (w_cls)
            C_DPI:         w_k = {{(K_W-12){1'b0}}, r_ir[21:10]};
            C_LD, C_ST:    w_k = {{(K_W-9){r_ir[20]}}, r_ir[20:12]};
            C_B:           w_k = {{(K_W-26){r_ir[25]}}, r_ir[25:0]};
            C_BCOND, C_CB: w_k = {{(K_W-19){r_ir[23]}}, r_ir[23:5]};
            default:       w_k = '0;
        endcase
    end

    // status = {N, Z, C, V}
    always_comb begin
        w_cond = 1'b0;
        case (r_ir[3:0])
            4'b0000: w_cond = i_status[2];
            4'b0001: w_cond = ~i_status[2];
            4'b1010: w_cond = (i_status[3] == i_status[0]);
            4'b1011: w_cond = (i_status[3] != i_status[0]);
            4'b1100: w_cond = ~i_status[2] & (i_status[3] == i_status[0]);
            4'b1101: w_cond = i_status[2] | (i_status[3] != i_status[0]);
            4'b1110: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_cls)
            C_B:     w_taken = 1'b1;
            C_BCOND: w_taken = w_cond;
            C_CB:    w_taken = r_cbnz ? ~i_alu_zero : i_alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    // Ready in the same cycle the count reaches the limit still completes the access.
    assign w_waiting = ((r_state == S_FETCH) && !i_imem_ready) ||
                       ((r_state == S_MEM) && !i_dmem_ready);
    assign w_timeout = w_waiting && (r_wait == WAIT_LIM);

    always_comb begin
        w_next      = r_state;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_load   = 1'b0;
        w_reg_we    = 1'b0;
        w_alu_b_k   = 1'b0;
        w_illegal   = 1'b0;
        w_load_ir   = 1'b0;
        w_retire    = 1'b0;
        w_set_fault = 1'b0;
        if (i_reset) begin
            w_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_imem_req = 1'b1;
                    if (i_imem_ready) begin
                        w_load_ir = 1'b1;
                        w_pc_inc  = 1'b1;
                        w_next    = S_DECODE;
                    end else if (w_timeout) begin
                        w_set_fault = 1'b1;
                        w_next      = S_HALT;
                    end
                end
                S_DECODE: begin
                    if (w_cls == C_NONE) begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_cls)
                        C_DPI: begin
                            w_alu_b_k = 1'b1;
                            w_next    = S_WB;
                        end
                        C_DPR: w_next = S_WB;
                        C_LD, C_ST: begin
                            w_alu_b_k = 1'b1;
                            w_next    = S_MEM;
                        end
                        C_B, C_BCOND, C_CB: begin
                            w_pc_load = w_taken;
                            w_retire  = 1'b1;
                            w_next    = S_FETCH;
                        end
                        default: w_next = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    w_dmem_req = 1'b1;
                    w_dmem_we  = (r_cls == C_ST);
                    if (i_dmem_ready) begin
                        if (r_cls == C_ST) begin
                            w_retire = 1'b1;
                            w_next   = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_timeout) begin
                        w_set_fault = 1'b1;
                        w_next      = S_HALT;
                    end
                end
                S_WB: begin
                    w_reg_we = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
                S_HALT:  w_next = S_HALT;
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_cls     <= C_NONE;
            r_cbnz    <= 1'b0;
            r_wait    <= '0;
            r_fault   <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_load_ir) begin
                r_ir <= i_imem_rdata;
            end
            if (r_state == S_DECODE) begin
                r_cls  <= w_cls;
                r_cbnz <= r_ir[24];
            end
            if (w_waiting && !w_timeout) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= '0;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign o_imem_req = w_imem_req;
    assign o_dmem_req = w_dmem_req;
    assign o_dmem_we  = w_dmem_we;
    assign o_pc_inc   = w_pc_inc;
    assign o_pc_load  = w_pc_load;
    assign o_reg_we   = w_reg_we;
    assign o_alu_b_k  = w_alu_b_k;
    assign o_illegal  = w_illegal;
    assign o_ir       = r_ir;
    assign o_k        = w_k;
    assign o_fault    = r_fault;
    assign o_retired  = r_retired;

endmodule

// File: doc/cu_seq_multicycle.md
Name: cu_seq_multicycle

Overview:
- Parametrised multi-cycle control sequencer for the LEGv8-style datapath; next generation of the single-class iFetch/reg control unit.
- Owns the instruction register and decodes DP-imm, DP-reg, load, store, B, B.cond and CBZ/CBNZ.
- Handshakes with instruction and data memory, with a wait-timeout fault.
- Generates the 64-bit-capable immediate `k` and counts retired instructions.

Parameters:
- K_W, 32: width of `k`; all immediates are sign- or zero-extended to K_W.
- WAIT_MAX, 15: maximum cycles a memory request may wait for ready before fault (1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_rdata  in  32  instruction word from instruction memory.
- imem_ready  in  1  instruction word valid this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_ready  in  1  data access complete this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1.
- status  in  4  NZCV flags from the status register.
- alu_zero  in  1  ALU zero result, valid in EXEC.
- ir  out  32  instruction register.
- k  out  K_W  immediate constant.
- pc_inc  out  1  PC += 4 strobe.
- pc_load  out  1  PC += k<<2 strobe (taken branch).
- reg_we  out  1  register-file write strobe.
- alu_b_k  out  1  ALU B operand selects k.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- fault  out  1  sticky memory-timeout flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clocking and reset:
  - One clock, `clock`. `reset` is synchronous, active-high.
  - Reset takes effect at the next rising edge regardless of state, including mid-wait: state=FETCH, ir=0, wait counter=0, fault=0, retired=0.
  - All strobes (imem_req, dmem_req, dmem_we, pc_inc, pc_load, reg_we, alu_b_k, illegal) are 0 during the reset cycle. An outstanding memory request is abandoned.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir<=imem_rdata, pc_inc=1 that cycle, next state DECODE.
- Decode, from ir, registered at the DECODE->EXEC edge:
  - DP-imm: ir[28:26]=100.
  - Branch class: ir[28:26]=101.
  - Load/store: ir[27]=1 and ir[25]=0; ir[22]=1 is load, else store.
  - DP-reg: ir[27:25]=101.
  - Within the branch class: ir[31:26]=000101 is B; ir[31:24]=01010100 is B.cond; ir[31:25]=1011010 is CBZ/CBNZ, with ir[24] selecting CBNZ.
  - Anything else is illegal.
- DECODE: if illegal, illegal=1 for one cycle and go to FETCH with no retire; else go to EXEC.
- EXEC:
  - DP-imm: alu_b_k=1, go to WB.
  - DP-reg: go to WB.
  - Load/store: alu_b_k=1, go to MEM.
  - Branch: pc_load=taken, retire, go to FETCH.
- Branch taken rules:
  - B: always taken.
  - CBZ: taken if alu_zero. CBNZ: taken if ~alu_zero.
  - B.cond on ir[3:0], with status = {N,Z,C,V}:
    - 0000 EQ: Z. 0001 NE: ~Z.
    - 1010 GE: N==V. 1011 LT: N!=V.
    - 1100 GT: ~Z & N==V. 1101 LE: Z | N!=V.
    - 1110 AL: 1.
    - All other codes: not taken.
- MEM:
  - dmem_req=1, dmem_we=store.
  - On dmem_ready: a load goes to WB; a store retires and goes to FETCH.
- WB: reg_we=1, retire, go to FETCH.
- HALT:
  - All strobes 0. Exit only by reset.
- Timeout:
  - Counter clears on entering FETCH or MEM and increments each cycle the request is held without ready.
  - When the count reaches WAIT_MAX with ready still 0: fault<=1, go to HALT.
  - Ready arriving in the same cycle the count hits WAIT_MAX wins: the access completes, no fault.
- Retire: retired increments by 1 on each retire event and wraps modulo 2^CNT_W.
- k, combinational from ir:
  - DP-imm: zero-extended ir[21:10].
  - Load/store: sign-extended ir[20:12].
  - B: sign-extended ir[25:0].
  - B.cond, CBZ, CBNZ: sign-extended ir[23:5].
  - Otherwise 0.
  - k is stable from DECODE until the next ir load.
- Latency per instruction, with zero-wait memory:
  - ALU ops: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.

Test Plan:
- Reset then ADDI with ir=0x91000C21, imem_ready=1 every cycle -> states F,D,E,W; k=3; alu_b_k=1 in EXEC; reg_we=1 in WB; retired=1 after 4 cycles.
- LDUR 0xF8408020 with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0; reg_we=1 next cycle; k=8.
- B.EQ 0x54000040 with status=0100 -> pc_load=1, k=2. Repeat with status=0000 -> pc_load=0, retired still increments.
- imem_ready held 0 with WAIT_MAX=15 -> fault=1 and HALT; strobes stay 0 for 20 cycles; reset clears fault and returns to FETCH.
- ir=0x00000000 -> illegal pulses once in DECODE; retired unchanged; next state FETCH.
- CNT_W=4, 16 retires -> retired wraps to 0. Reset asserted mid-MEM -> dmem_req=0 next cycle, state FETCH.
